multicycle_controller: RTL and testbench

- Main control FSM for the multi-cycle version of the core: one shared ALU and one unified instruction/data memory, reused across the fetch, decode, execute, memory and writeback steps of each instruction.
- Decodes Opcode and sequences the datapath muxes and write enables.
- Drives ALUOp into the existing ALU decoder: 00 = add, 01 = sub, 10 = use Funct.
- Stalls on a memory-ready handshake.

---
 rtl/multicycle_controller.sv | 171 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle core: sequences the shared ALU/memory datapath.
// Optional retired-instruction counter compiled in with `define MCYC_PERF_CNT_EN.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic             PCEn,
    output logic             IllegalOp,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state_q, state_d;
    logic       illegal;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            // Opcode is held by the IR, so it still selects load vs store here
            S_MEMADR: state_d = (Opcode == OP_SW) ? S_MEMWR :
                                (Opcode == OP_LW) ? S_MEMRD : S_FETCH;
            S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        PCSrc     = 2'b00;
        PCEn      = 1'b0;
        IllegalOp = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCEn    = MemReady;
                end
                S_DECODE: begin
                    ALUSrcB   = 2'b11;
                    IllegalOp = illegal;
                end
                S_MEMADR, S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b01;
                    PCSrc   = 2'b01;
                    PCEn    = Zero;
                end
                S_ADDIWB: RegWrite = 1'b1;
                S_JUMP: begin
                    PCSrc = 2'b10;
                    PCEn  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign State = reset ? S_FETCH : state_q;

`ifdef MCYC_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             retire;

    // Illegal-opcode returns come from DECODE and are deliberately not counted
    assign retire = (state_d == S_FETCH) &&
                    (state_q inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP});

    always_ff @(posedge clk) begin
        if (reset)       cnt_q <= '0;
        else if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign InstrCount = reset ? '0 : cnt_q;
`else
    assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: vector table, corner-case sequences and a
// randomized run against a step-queue reference model.
module tb_multicycle_controller;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    Opcode;
    logic          Zero;
    logic          MemReady;
    logic          IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]    ALUSrcB, ALUOp, PCSrc;
    logic          PCEn, IllegalOp;
    logic [3:0]    State;
    logic [CW-1:0] InstrCount;

    multicycle_controller #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
        .IllegalOp(IllegalOp), .State(State), .InstrCount(InstrCount)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    wire [19:0] dut_v = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                         ALUSrcB, ALUOp, PCSrc, PCEn, IllegalOp, State};

    // Reference model: current step plus the queue of steps still owed by the instruction
    logic [3:0]    m_step = 4'd0;
    logic [3:0]    m_q[$];
    logic [CW-1:0] m_cnt = '0;

    // Values observed at the last sample point
    logic [19:0]   obs_v;
    logic [CW-1:0] obs_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    function automatic logic [19:0] expv(input logic rst, input logic [3:0] st,
                                         input logic [5:0] op, input logic z, input logic mr);
        logic iord, mrd, mw, irw, rdst, mtr, rw, srca, pcen, ill;
        logic [1:0] srcb, aluop, pcsrc;
        {iord, mrd, mw, irw, rdst, mtr, rw, srca, pcen, ill} = '0;
        {srcb, aluop, pcsrc} = '0;
        if (rst) return 20'h0;
        case (st)
            4'd0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcen = mr; end
            4'd1:  begin srcb = 2'b11; ill = !is_legal(op); end
            4'd2:  begin srca = 1; srcb = 2'b10; end
            4'd3:  begin iord = 1; mrd = 1; end
            4'd4:  begin mtr = 1; rw = 1; end
            4'd5:  begin iord = 1; mw = 1; end
            4'd6:  begin srca = 1; aluop = 2'b10; end
            4'd7:  begin rdst = 1; rw = 1; end
            4'd8:  begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; pcen = z; end
            4'd9:  begin srca = 1; srcb = 2'b10; end
            4'd10: rw = 1;
            4'd11: begin pcsrc = 2'b10; pcen = 1; end
            default: ;
        endcase
        return {iord, mrd, mw, irw, rdst, mtr, rw, srca, srcb, aluop, pcsrc, pcen, ill, st};
    endfunction

    task automatic model_adv(input logic rst, input logic [5:0] op, input logic mr);
        if (rst) begin
            m_step = 4'd0;
            m_q.delete();
            m_cnt  = '0;
        end else if (m_step inside {4'd0, 4'd3, 4'd5} && !mr) begin
            // stalled on memory
        end else if (m_step == 4'd0) begin
            m_step = 4'd1;
        end else if (m_step == 4'd1) begin
            case (op)
                6'b000000: m_q = '{4'd6, 4'd7};
                6'b100011: m_q = '{4'd2, 4'd3, 4'd4};
                6'b101011: m_q = '{4'd2, 4'd5};
                6'b000100: m_q = '{4'd8};
                6'b001000: m_q = '{4'd9, 4'd10};
                6'b000010: m_q = '{4'd11};
                default:   m_q.delete();
            endcase
            m_step = (m_q.size() > 0) ? m_q.pop_front() : 4'd0;
        end else if (m_q.size() > 0) begin
            m_step = m_q.pop_front();
        end else begin
            m_step = 4'd0;
            m_cnt  = m_cnt + 1'b1;
        end
    endtask

    // One clock: drive, sample mid-cycle against the model, then advance the model
    task automatic cyc(input logic r, input logic [5:0] op, input logic z, input logic mr);
        logic [CW-1:0] ecnt;
        reset = r; Opcode = op; Zero = z; MemReady = mr;
        @(negedge clk);
        obs_v   = dut_v;
        obs_cnt = InstrCount;
        chk("outputs", {12'h0, obs_v}, {12'h0, expv(r, m_step, op, z, mr)});
`ifdef MCYC_PERF_CNT_EN
        ecnt = r ? '0 : m_cnt;
`else
        ecnt = '0;
`endif
        chk("InstrCount", 32'(obs_cnt), 32'(ecnt));
        @(posedge clk);
        model_adv(r, op, mr);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       z;
        logic       mr;
        logic [3:0] st;
        logic       rw;
        logic       pcen;
        logic       ill;
        logic       mw;
    } vec_t;

    vec_t tbl[23];

    initial begin
        int n_irw, n_pcen, n_ld;
        logic [5:0] cur_op;
        logic bad_rw, bad_mw;
        logic [3:0] mr_pat;
        logic [7:0] lw_mr;

        tbl[0]  = '{1, 6'o00, 0, 1, 4'd0,  0, 0, 0, 0};
        tbl[1]  = '{1, 6'o00, 0, 1, 4'd0,  0, 0, 0, 0};
        tbl[2]  = '{1, 6'o00, 0, 1, 4'd0,  0, 0, 0, 0};
        tbl[3]  = '{0, 6'b000000, 0, 1, 4'd0, 0, 1, 0, 0};
        tbl[4]  = '{0, 6'b000000, 0, 1, 4'd1, 0, 0, 0, 0};
        tbl[5]  = '{0, 6'b000000, 0, 1, 4'd6, 0, 0, 0, 0};
        tbl[6]  = '{0, 6'b000000, 0, 1, 4'd7, 1, 0, 0, 0};
        tbl[7]  = '{0, 6'b000100, 1, 1, 4'd0, 0, 1, 0, 0};
        tbl[8]  = '{0, 6'b000100, 1, 1, 4'd1, 0, 0, 0, 0};
        tbl[9]  = '{0, 6'b000100, 1, 1, 4'd8, 0, 1, 0, 0};
        tbl[10] = '{0, 6'b000100, 0, 1, 4'd0, 0, 1, 0, 0};
        tbl[11] = '{0, 6'b000100, 0, 1, 4'd1, 0, 0, 0, 0};
        tbl[12] = '{0, 6'b000100, 0, 1, 4'd8, 0, 0, 0, 0};
        tbl[13] = '{0, 6'b111111, 0, 1, 4'd0, 0, 1, 0, 0};
        tbl[14] = '{0, 6'b111111, 0, 1, 4'd1, 0, 0, 1, 0};
        tbl[15] = '{0, 6'b111111, 0, 1, 4'd0, 0, 1, 0, 0};
        tbl[16] = '{0, 6'b000010, 0, 1, 4'd1, 0, 0, 0, 0};
        tbl[17] = '{0, 6'b000010, 0, 1, 4'd11, 0, 1, 0, 0};
        tbl[18] = '{0, 6'b101011, 0, 1, 4'd0, 0, 1, 0, 0};
        tbl[19] = '{0, 6'b101011, 0, 1, 4'd1, 0, 0, 0, 0};
        tbl[20] = '{0, 6'b101011, 0, 1, 4'd2, 0, 0, 0, 0};
        tbl[21] = '{0, 6'b101011, 0, 1, 4'd5, 0, 0, 0, 1};
        tbl[22] = '{0, 6'b101011, 0, 1, 4'd0, 0, 1, 0, 0};

        reset = 1'b1; Opcode = '0; Zero = 1'b0; MemReady = 1'b1;
        #1;
        for (int i = 0; i < 23; i++) begin
            cyc(tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].mr);
            chk($sformatf("tbl%0d.State", i),     32'(obs_v[3:0]), 32'(tbl[i].st));
            chk($sformatf("tbl%0d.RegWrite", i),  32'(obs_v[13]),  32'(tbl[i].rw));
            chk($sformatf("tbl%0d.PCEn", i),      32'(obs_v[5]),   32'(tbl[i].pcen));
            chk($sformatf("tbl%0d.IllegalOp", i), 32'(obs_v[4]),   32'(tbl[i].ill));
            chk($sformatf("tbl%0d.MemWrite", i),  32'(obs_v[17]),  32'(tbl[i].mw));
        end

        // lw: two FETCH stalls and one MEMRD stall -> 8 cycles
        cyc(1, 6'b100011, 0, 1);
        lw_mr = 8'b11011100;  // applied LSB first: 0,0,1,1,1,0,1,1
        n_irw = 0; n_pcen = 0; n_ld = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 6'b100011, 0, lw_mr[i]);
            n_irw  += int'(obs_v[16]);
            n_pcen += int'(obs_v[5]);
            if (obs_v[3:0] == 4'd4 && obs_v[13] && obs_v[14]) n_ld++;
        end
        chk("lw.IRWrite_pulses", 32'(n_irw), 32'd1);
        chk("lw.PCEn_pulses", 32'(n_pcen), 32'd1);
        chk("lw.load_writeback", 32'(n_ld), 32'd1);
        cyc(0, 6'b100011, 0, 1);
        chk("lw.back_in_fetch", 32'(obs_v[3:0]), 32'd0);

        // Reset arriving while a store waits in MEMWR
        cyc(1, 6'b101011, 0, 1);
        cyc(0, 6'b101011, 0, 1);
        cyc(0, 6'b101011, 0, 1);
        cyc(0, 6'b101011, 0, 1);
        cyc(0, 6'b101011, 0, 0);
        chk("rstmid.in_memwr", 32'(obs_v[3:0]), 32'd5);
        cyc(1, 6'b101011, 0, 0);
        chk("rstmid.MemWrite", 32'(obs_v[17]), 32'd0);
        chk("rstmid.RegWrite", 32'(obs_v[13]), 32'd0);
        cyc(0, 6'b101011, 0, 0);
        chk("rstmid.State_next", 32'(obs_v[3:0]), 32'd0);
        chk("rstmid.MemWrite_next", 32'(obs_v[17]), 32'd0);

        // 17 R-type instructions on a 4-bit counter wrap to 1
        cyc(1, 6'b000000, 0, 1);
        for (int i = 0; i < 17 * 4; i++) cyc(0, 6'b000000, 0, 1);
        cyc(0, 6'b000000, 0, 1);
`ifdef MCYC_PERF_CNT_EN
        chk("cnt.wrap17", 32'(obs_cnt), 32'd1);
`else
        chk("cnt.tied0", 32'(obs_cnt), 32'd0);
`endif

        // Randomized run; the opcode only changes between instructions, as the IR holds it
        cyc(1, 6'b000000, 0, 1);
        cur_op = 6'b000000;
        bad_rw = 1'b0; bad_mw = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            logic r;
            if (m_step == 4'd0) begin
                case ($urandom_range(0, 6))
                    0: cur_op = 6'b000000;
                    1: cur_op = 6'b100011;
                    2: cur_op = 6'b101011;
                    3: cur_op = 6'b000100;
                    4: cur_op = 6'b001000;
                    5: cur_op = 6'b000010;
                    default: cur_op = 6'($urandom);
                endcase
            end
            mr_pat = 4'($urandom);
            r = ($urandom_range(0, 49) == 0);
            cyc(r, cur_op, 1'($urandom), mr_pat != 4'd0);
            if (r && obs_v[13]) bad_rw = 1'b1;
            if (r && obs_v[17]) bad_mw = 1'b1;
        end
        chk("rand.no_regwrite_in_reset", 32'(bad_rw), 32'd0);
        chk("rand.no_memwrite_in_reset", 32'(bad_mw), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
